// File: rtl/mem_pkg.sv
// Shared MEM-stage types: FSM state encoding, default widths and the MEM/WB bundle
// consumed by the writeback stage.
package mem_pkg;

  localparam int unsigned MEM_XLEN       = 64;
  localparam int unsigned MEM_REG_ADDR_W = 5;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [MEM_XLEN-1:0]       Read_Data;
    logic [MEM_XLEN-1:0]       Result;
    logic [MEM_REG_ADDR_W-1:0] rd;
    logic                      MemtoReg;
    logic                      RegWrite;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM stage: runs the data-memory req/ack access for the EX/MEM bundle and loads MEM/WB.
// Optional MEM_MISALIGN_CHK_EN rejects accesses whose address is not 8-byte aligned.
module mem_wb_stage #(
  parameter int unsigned XLEN           = mem_pkg::MEM_XLEN,
  parameter int unsigned REG_ADDR_W     = mem_pkg::MEM_REG_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       EX_MEM_Result,
  input  logic [XLEN-1:0]       Write_Data,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  EX_MEM_MemRead,
  input  logic                  EX_MEM_MemWrite,
  input  logic                  EX_MEM_MemtoReg,
  input  logic                  EX_MEM_RegWrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  mem_stall,
  output logic                  dmem_timeout,
  output logic [XLEN-1:0]       MEM_WB_Read_Data,
  output logic [XLEN-1:0]       MEM_WB_Result,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  MEM_WB_MemtoReg,
  output logic                  MEM_WB_RegWrite
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic                  misalign
`endif
);

  import mem_pkg::*;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  mem_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  timeout_q, timeout_d;
  logic [XLEN-1:0]       wb_rdata_q, wb_rdata_d;
  logic [XLEN-1:0]       wb_result_q, wb_result_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_m2r_q, wb_m2r_d;
  logic                  wb_rw_q, wb_rw_d;
  logic                  misalign_d;

  logic acc, is_load, addr_bad, timeout_hit;

  assign acc     = EX_MEM_MemRead | EX_MEM_MemWrite;
  // A combined read+write bundle is treated as a store.
  assign is_load = EX_MEM_MemRead & ~EX_MEM_MemWrite;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));

`ifdef MEM_MISALIGN_CHK_EN
  logic misalign_q;
  assign addr_bad = |EX_MEM_Result[2:0];
  assign misalign = misalign_q;
`else
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timeout_d   = 1'b0;
    misalign_d  = 1'b0;
    wb_rdata_d  = wb_rdata_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_m2r_d    = wb_m2r_q;
    wb_rw_d     = wb_rw_q;
    mem_stall   = 1'b0;

    unique case (state_q)
      MS_IDLE: begin
        if (!acc) begin
          wb_rdata_d  = '0;
          wb_result_d = EX_MEM_Result;
          wb_rd_d     = EX_MEM_rd;
          wb_m2r_d    = EX_MEM_MemtoReg;
          wb_rw_d     = EX_MEM_RegWrite;
        end else begin
          wb_rdata_d  = '0;
          wb_result_d = '0;
          wb_rd_d     = '0;
          wb_m2r_d    = 1'b0;
          wb_rw_d     = 1'b0;
          if (addr_bad) begin
            misalign_d = 1'b1;
          end else begin
            mem_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = EX_MEM_MemWrite;
            addr_d    = EX_MEM_Result;
            wdata_d   = EX_MEM_MemWrite ? Write_Data : '0;
            cnt_d     = '0;
            state_d   = MS_WAIT;
          end
        end
      end
      MS_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = MS_IDLE;
          if (dmem_ack) begin
            wb_rdata_d  = is_load ? dmem_rdata : '0;
            wb_result_d = EX_MEM_Result;
            wb_rd_d     = EX_MEM_rd;
            wb_m2r_d    = EX_MEM_MemtoReg;
            wb_rw_d     = EX_MEM_RegWrite;
          end else begin
            // Abort: MEM/WB already holds the bubble loaded on entry.
            timeout_d = 1'b1;
          end
        end else begin
          mem_stall = 1'b1;
          if (TIMEOUT_CYCLES != 0) cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MS_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timeout_q   <= 1'b0;
      wb_rdata_q  <= '0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_m2r_q    <= 1'b0;
      wb_rw_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timeout_q   <= timeout_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_m2r_q    <= wb_m2r_d;
      wb_rw_q     <= wb_rw_d;
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  logic unused_misalign;
  assign unused_misalign = misalign_d;
`endif

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_timeout     = timeout_q;
  assign MEM_WB_Read_Data = wb_rdata_q;
  assign MEM_WB_Result    = wb_result_q;
  assign MEM_WB_rd        = wb_rd_q;
  assign MEM_WB_MemtoReg  = wb_m2r_q;
  assign MEM_WB_RegWrite  = wb_rw_q;

endmodule
